ps2_key_rx: RTL

Receives raw PS/2 keyboard frames (device-driven clock/data lines) and produces the 11-bit `ps2_key` event word consumed by `system`: scan code, extended flag, pressed flag and a toggle bit that flips once per event. Sits between the board's PS/2 connector pins and the `ps2_key` input of `system`, giving the test harness a native keyboard path alongside the HPS-supplied one. Handles line synchronisation, glitch filtering, frame checking, mid-frame timeout, and E0/F0 prefix folding.

---
 rtl/ps2_key_rx_if.sv | 24 ++
 rtl/ps2_key_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx_if.sv
// rtl/ps2_key_rx_if.sv - PS/2 pin and key-event bundle between connector side and ps2_key_rx
interface ps2_key_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver producing the 11-bit ps2_key event word
// Optional build macro: PS2_KEY_PARITY_EN (reject frames with bad odd parity).
module ps2_key_rx #(
    parameter int          FILTER  = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    ps2_key_rx_if.slave  bus
);

    localparam int FW = $clog2(FILTER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic        r_clk_s1;
    logic        r_clk_s2;
    logic        r_dat_s1;
    logic        r_dat_s2;
    logic        r_fclk;
    logic [FW-1:0] r_filt_cnt;
    logic        r_strobe;
    logic        r_sample;

    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [15:0] r_to_cnt;
    logic        r_ext_f;
    logic        r_rel_f;
    logic [10:0] r_key;
    logic        r_err;

    logic        w_filt_done;
    logic        w_fclk_fall;
    logic        w_frame_done;
    logic        w_timeout;
    logic        w_parity_ok;
    logic        w_accept;
    logic        w_reject;

    // Filtered clock flips only after the synchronised level has differed for FILTER cycles
    assign w_filt_done = (r_clk_s2 != r_fclk) && (r_filt_cnt == FW'(FILTER - 1));
    assign w_fclk_fall = w_filt_done && r_fclk;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_fclk     <= 1'b1;
            r_filt_cnt <= '0;
            r_strobe   <= 1'b0;
            r_sample   <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_strobe <= w_fclk_fall;
            if (w_fclk_fall) begin
                r_sample <= r_dat_s2;
            end
            if (r_clk_s2 == r_fclk) begin
                r_filt_cnt <= '0;
            end else if (w_filt_done) begin
                r_fclk     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_strobe && !r_sample) begin
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (r_strobe && (r_bit_cnt == 3'd7)) begin
                    w_state_nx = S_PARITY;
                end
            end
            S_PARITY: begin
                if (r_strobe) begin
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (r_strobe) begin
                    w_state_nx   = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && !r_strobe && (r_to_cnt == TIMEOUT - 16'd1)) begin
            w_timeout  = 1'b1;
            w_state_nx = S_IDLE;
        end
    end

`ifdef PS2_KEY_PARITY_EN
    logic r_par;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_par <= 1'b0;
        end else if (r_strobe && (r_state == S_PARITY)) begin
            r_par <= r_sample;
        end
    end

    assign w_parity_ok = ^{r_shift, r_par};
`else
    assign w_parity_ok = 1'b1;
`endif

    // r_sample holds the stop bit while in S_STOP
    assign w_accept = w_frame_done && r_sample && w_parity_ok;
    assign w_reject = (w_frame_done && !w_accept) || w_timeout;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_to_cnt  <= 16'd0;
            r_ext_f   <= 1'b0;
            r_rel_f   <= 1'b0;
            r_key     <= 11'h000;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_reject;

            if (r_strobe) begin
                if (r_state == S_IDLE) begin
                    r_bit_cnt <= 3'd0;
                end else if (r_state == S_DATA) begin
                    r_shift   <= {r_sample, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end

            if ((r_state == S_IDLE) || (w_state_nx == S_IDLE) || r_strobe) begin
                r_to_cnt <= 16'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end

            if (w_reject) begin
                r_ext_f <= 1'b0;
                r_rel_f <= 1'b0;
            end else if (w_accept) begin
                case (r_shift)
                    8'hE0: r_ext_f <= 1'b1;
                    8'hF0: r_rel_f <= 1'b1;
                    8'hE1: begin
                    end
                    default: begin
                        r_key   <= {~r_key[10], ~r_rel_f, r_ext_f, r_shift};
                        r_ext_f <= 1'b0;
                        r_rel_f <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ps2_key   = r_key;
    assign bus.frame_err = r_err;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
